// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Desc    : Shared state encoding, load-width codes and byte-enable constants.
// Rev     : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] EXTR_BYTE = 2'b01;
  localparam logic [1:0] EXTR_HALF = 2'b10;

  localparam logic [3:0] c_BE_ALL     = 4'b1111;
  localparam logic [3:0] c_BE_LO_HALF = 4'b0011;
  localparam logic [3:0] c_BE_HI_HALF = 4'b1100;
  localparam logic [3:0] c_BE_BYTE0   = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extract.sv
`default_nettype none
// ============================================================================
// Module  : load_extract
// Desc    : Selects the addressed byte/half of a read word and extends it.
// Rev     : 1.0 - initial release
// ============================================================================
module load_extract
  import mem_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic [DATA_BITS-1:0] rdata,
  input  logic [1:0]           lane,
  input  logic [1:0]           extr_word,
  input  logic                 extr_signed,
  output logic [DATA_BITS-1:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{lane, 3'b000} +: 8];
    w_half = lane[1] ? rdata[31:16] : rdata[15:0];
    case (extr_word)
      EXTR_BYTE: load_data = {{(DATA_BITS-8){extr_signed & w_byte[7]}}, w_byte};
      EXTR_HALF: load_data = {{(DATA_BITS-16){extr_signed & w_half[15]}}, w_half};
      default:   load_data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Desc    : MEM-stage req/ack data-memory controller with lane steering.
// Rev     : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 mem_write,
  input  logic                 mem_to_reg,
  input  logic                 sb,
  input  logic                 sh,
  input  logic [1:0]           extr_word,
  input  logic                 extr_signed,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [ADDR_BITS-1:0] dm_addr,
  output logic [3:0]           dm_be,
  output logic [DATA_BITS-1:0] dm_wdata,
  input  logic                 dm_ack,
  input  logic [DATA_BITS-1:0] dm_rdata,
  output logic [DATA_BITS-1:0] load_data,
  output logic                 done,
  output logic                 busy,
  output logic                 misalign,
  output logic                 bus_err
);

  localparam int             c_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  state_t                 r_state, w_state_next;
  logic [c_CNT_W-1:0]     r_cnt, w_cnt_next;
  logic                   r_req, w_req_next;
  logic                   r_we, w_we_next;
  logic [ADDR_BITS-1:0]   r_addr, w_addr_next;
  logic [3:0]             r_be, w_be_next;
  logic [DATA_BITS-1:0]   r_wdata, w_wdata_next;
  logic [DATA_BITS-1:0]   r_ld, w_ld_next;
  logic                   r_done, w_done_next;
  logic                   r_mis, w_mis_next;
  logic                   r_berr, w_berr_next;
  logic                   r_is_load, w_is_load_next;
  logic [1:0]             r_lane, w_lane_next;
  logic [1:0]             r_extr, w_extr_next;
  logic                   r_sign, w_sign_next;

  logic                   w_start;
  logic                   w_aligned;
  logic [3:0]             w_be;
  logic [DATA_BITS-1:0]   w_wdata;
  logic [DATA_BITS-1:0]   w_extracted;

  assign w_start = in_valid & (mem_write | mem_to_reg);

  // Lane steering and alignment; a store takes priority over a load.
  always_comb begin
    w_be      = c_BE_ALL;
    w_wdata   = wdata;
    w_aligned = 1'b1;
    if (mem_write) begin
      if (sb) begin
        w_be    = c_BE_BYTE0 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end else if (sh) begin
        w_be      = addr[1] ? c_BE_HI_HALF : c_BE_LO_HALF;
        w_wdata   = {2{wdata[15:0]}};
        w_aligned = ~addr[0];
      end else begin
        w_aligned = (addr[1:0] == 2'b00);
      end
    end else begin
      case (extr_word)
        EXTR_BYTE: w_aligned = 1'b1;
        EXTR_HALF: w_aligned = ~addr[0];
        default:   w_aligned = (addr[1:0] == 2'b00);
      endcase
    end
  end

  load_extract #(
    .DATA_BITS (DATA_BITS)
  ) u_load_extract (
    .rdata       (dm_rdata),
    .lane        (r_lane),
    .extr_word   (r_extr),
    .extr_signed (r_sign),
    .load_data   (w_extracted)
  );

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_req_next     = r_req;
    w_we_next      = r_we;
    w_addr_next    = r_addr;
    w_be_next      = r_be;
    w_wdata_next   = r_wdata;
    w_ld_next      = r_ld;
    w_done_next    = 1'b0;
    w_mis_next     = 1'b0;
    w_berr_next    = 1'b0;
    w_is_load_next = r_is_load;
    w_lane_next    = r_lane;
    w_extr_next    = r_extr;
    w_sign_next    = r_sign;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_aligned) begin
            w_addr_next    = {addr[ADDR_BITS-1:2], 2'b00};
            w_we_next      = mem_write;
            w_be_next      = w_be;
            w_wdata_next   = w_wdata;
            w_req_next     = 1'b1;
            w_cnt_next     = '0;
            w_is_load_next = ~mem_write;
            w_lane_next    = addr[1:0];
            w_extr_next    = extr_word;
            w_sign_next    = extr_signed;
            w_state_next   = ST_REQ;
          end else begin
            w_mis_next   = 1'b1;
            w_done_next  = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (dm_ack) begin
          w_req_next   = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = ST_DONE;
          if (r_is_load) begin
            w_ld_next = w_extracted;
          end
        end else if (r_cnt == c_CNT_LAST) begin
          w_req_next   = 1'b0;
          w_berr_next  = 1'b1;
          w_done_next  = 1'b1;
          w_ld_next    = '0;
          w_state_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_ld      <= '0;
      r_done    <= 1'b0;
      r_mis     <= 1'b0;
      r_berr    <= 1'b0;
      r_is_load <= 1'b0;
      r_lane    <= '0;
      r_extr    <= '0;
      r_sign    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_req     <= w_req_next;
      r_we      <= w_we_next;
      r_addr    <= w_addr_next;
      r_be      <= w_be_next;
      r_wdata   <= w_wdata_next;
      r_ld      <= w_ld_next;
      r_done    <= w_done_next;
      r_mis     <= w_mis_next;
      r_berr    <= w_berr_next;
      r_is_load <= w_is_load_next;
      r_lane    <= w_lane_next;
      r_extr    <= w_extr_next;
      r_sign    <= w_sign_next;
    end
  end

  // DONE leaves busy low so EX/MEM advances at the end of the completion cycle.
  assign busy      = (r_state == ST_REQ) | ((r_state == ST_IDLE) & w_start);
  assign dm_req    = r_req;
  assign dm_we     = r_we;
  assign dm_addr   = r_addr;
  assign dm_be     = r_be;
  assign dm_wdata  = r_wdata;
  assign load_data = r_ld;
  assign done      = r_done;
  assign misalign  = r_mis;
  assign bus_err   = r_berr;

endmodule
`default_nettype wire
